// File: rtl/dmem_ram_vec.sv
// rtl/dmem_ram_vec.sv - byte-organised data memory with scalar and 24-lane vector access
module dmem_ram_vec #(
    parameter int DEPTH = 1024,
    parameter int LANES = 24,
    parameter int AW    = 32
) (
    input  logic              clk,
    input  logic              switchStart,
    input  logic              isVector,
    input  logic              we,
    input  logic [AW-1:0]     address,
    input  logic [LANES*8-1:0] wd,
    output logic [LANES*8-1:0] rd
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] addr_mod;
    logic [AW:0]   lane_sum [LANES];
    logic [IW-1:0] lane_idx [LANES];

    // Lanes past the top of the array wrap to the bottom; one subtract
    // suffices because addr_mod < DEPTH and LANES <= DEPTH.
    always_comb begin
        addr_mod = address % AW'(DEPTH);
        for (int i = 0; i < LANES; i++) begin
            lane_sum[i] = {1'b0, addr_mod} + (AW+1)'(i);
            if (lane_sum[i] >= (AW+1)'(DEPTH)) begin
                lane_idx[i] = IW'(lane_sum[i] - (AW+1)'(DEPTH));
            end else begin
                lane_idx[i] = lane_sum[i][IW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (switchStart) begin
            mem <= '{default: 8'h00};
        end else if (we) begin
            if (isVector) begin
                for (int i = 0; i < LANES; i++) begin
                    mem[lane_idx[i]] <= wd[8*i +: 8];
                end
            end else begin
                mem[lane_idx[0]] <= wd[7:0];
            end
        end
    end

    always_comb begin
        rd = '0;
        if (isVector) begin
            for (int i = 0; i < LANES; i++) begin
                rd[8*i +: 8] = mem[lane_idx[i]];
            end
        end else begin
            rd[7:0] = mem[lane_idx[0]];
        end
    end

endmodule

// File: tb/tb_dmem_ram_vec.sv
// tb/tb_dmem_ram_vec.sv - self-checking bench for dmem_ram_vec
module tb_dmem_ram_vec;

    localparam int DEPTH = 1024;
    localparam int LANES = 24;

    logic         clk;
    logic         switchStart;
    logic         isVector;
    logic         we;
    logic [31:0]  address;
    logic [191:0] wd;
    logic [191:0] rd;

    int tests;
    int fails;
    bit chk_en;

    logic [7:0] model [DEPTH];

    dmem_ram_vec #(.DEPTH(DEPTH), .LANES(LANES), .AW(32)) dut (
        .clk         (clk),
        .switchStart (switchStart),
        .isVector    (isVector),
        .we          (we),
        .address     (address),
        .wd          (wd),
        .rd          (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [191:0] model_rd(input logic [31:0] a, input logic v);
        logic [191:0] r;
        int unsigned  base;
        r = '0;
        base = a % DEPTH;
        if (v) begin
            for (int i = 0; i < LANES; i++) r[8*i +: 8] = model[(base + i) % DEPTH];
        end else begin
            r[7:0] = model[base];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        int unsigned base;
        base = address % DEPTH;
        if (switchStart) begin
            for (int j = 0; j < DEPTH; j++) model[j] = 8'h00;
        end else if (we) begin
            if (isVector) begin
                for (int i = 0; i < LANES; i++) model[(base + i) % DEPTH] = wd[8*i +: 8];
            end else begin
                model[base] = wd[7:0];
            end
        end
    end

    always @(negedge clk) begin
        logic [191:0] exp_rd;
        if (chk_en) begin
            exp_rd = model_rd(address, isVector);
            tests++;
            if (rd !== exp_rd) begin
                fails++;
                $display("FAIL model_cmp addr=%0d vec=%0b got=%h exp=%h", address, isVector, rd, exp_rd);
            end
        end
    end

    task automatic drive(input logic s, input logic w, input logic v,
                         input logic [31:0] a, input logic [191:0] d);
        @(posedge clk);
        #1;
        switchStart = s;
        we          = w;
        isVector    = v;
        address     = a;
        wd          = d;
    endtask

    task automatic lit(input string name, input logic [191:0] exp_rd);
        @(negedge clk);
        tests++;
        if (rd !== exp_rd) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", name, rd, exp_rd);
        end
    endtask

    initial begin
        logic [191:0] wrap_wd;
        logic [191:0] rnd_wd;
        logic [31:0]  rnd_a;
        int           addrs [3];

        tests = 0;
        fails = 0;
        chk_en = 1'b0;
        switchStart = 1'b1;
        we = 1'b0;
        isVector = 1'b0;
        address = '0;
        wd = '0;
        repeat (5) @(posedge clk);
        drive(0, 0, 0, 0, '0);
        chk_en = 1'b1;

        addrs = '{0, 2, DEPTH-1};
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, addrs[k], '0);
            lit("reset_scalar", 192'd0);
            drive(0, 0, 1, addrs[k], '0);
            lit("reset_vector", 192'd0);
        end

        drive(0, 1, 0, 0, 192'd33);
        drive(0, 0, 0, 0, '0);
        lit("scalar_rd0", 192'd33);
        drive(0, 0, 0, 1, '0);
        lit("scalar_mem1", 192'd0);

        drive(0, 1, 1, 2, 192'd123456789112);
        drive(0, 0, 1, 2, '0);
        lit("vector_rd2", 192'd123456789112);
        drive(0, 0, 0, 0, '0);
        lit("vector_keep0", 192'd33);
        drive(0, 0, 0, 6, '0);
        lit("vector_mem6", 192'h1C);
        drive(0, 0, 0, 7, '0);
        lit("vector_mem7", 192'd0);
        drive(0, 0, 0, 25, '0);
        lit("vector_mem25", 192'd0);

        for (int i = 0; i < LANES; i++) wrap_wd[8*i +: 8] = 8'hA0 + 8'(i);
        drive(0, 1, 1, DEPTH-2, wrap_wd);
        drive(0, 0, 1, DEPTH-2, '0);
        lit("wrap_vec", wrap_wd);
        drive(0, 0, 0, DEPTH-1, '0);
        lit("wrap_top", 192'hA1);
        drive(0, 0, 0, 0, '0);
        lit("wrap_mem0", 192'hA2);
        drive(0, 0, 0, 21, '0);
        lit("wrap_mem21", 192'hB7);
        drive(0, 0, 0, 32'h0001_0000, '0);
        lit("upper_addr_ignored", 192'hA2);

        drive(1, 1, 0, 5, 192'hFF);
        drive(0, 0, 0, 5, '0);
        lit("priority_mem5", 192'd0);
        drive(0, 0, 1, DEPTH-2, '0);
        lit("priority_clear", 192'd0);

        drive(0, 1, 0, 10, 192'h11);
        drive(0, 1, 0, 10, 192'h55);
        lit("rdw_old", 192'h11);
        drive(0, 0, 0, 10, '0);
        lit("rdw_new", 192'h55);

        for (int n = 0; n < 3000; n++) begin
            rnd_wd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            case ($urandom_range(0, 3))
                0:       rnd_a = $urandom();
                1:       rnd_a = DEPTH - LANES + $urandom_range(0, LANES);
                2:       rnd_a = $urandom_range(0, 40);
                default: rnd_a = $urandom_range(0, DEPTH-1);
            endcase
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0),
                  $urandom_range(0, 1), rnd_a, rnd_wd);
        end
        drive(0, 0, 0, 0, '0);
        @(negedge clk);
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
